// File: rtl/score_keeper_if.sv
// Command/score bundle between the game control FSM and score_keeper.
// ROUND_COUNT_EN adds the Rondas round counter to the bundle.
interface score_keeper_if #(
    parameter int WIDTH = 4
);
    logic             Modo;
    logic             ModifA;
    logic             ModifB;
    logic [WIDTH-1:0] ScoreA;
    logic [WIDTH-1:0] ScoreB;
    logic             GanadorA;
    logic             GanadorB;
`ifdef ROUND_COUNT_EN
    logic [7:0]       Rondas;
`endif

    modport master (
        output Modo, ModifA, ModifB,
        input  ScoreA, ScoreB, GanadorA, GanadorB
`ifdef ROUND_COUNT_EN
        , input Rondas
`endif
    );

    modport slave (
        input  Modo, ModifA, ModifB,
        output ScoreA, ScoreB, GanadorA, GanadorB
`ifdef ROUND_COUNT_EN
        , output Rondas
`endif
    );
endinterface

// File: rtl/score_keeper.sv
// Saturating two-player score tracker with a sticky winner FSM.
// Optional feature macro: ROUND_COUNT_EN (adds the 8-bit Rondas event counter).
//
// state | meaning
// PLAY  | scores follow ModifA/ModifB rising edges
// WON_A | player A reached WIN_SCORE; scores frozen until Reset
// WON_B | player B reached WIN_SCORE; scores frozen until Reset
module score_keeper #(
    parameter int WIDTH     = 4,
    parameter int WIN_SCORE = 5
) (
    input  logic                 clock,
    input  logic                 Reset,
    score_keeper_if.slave        bus
);
    typedef enum logic [1:0] {PLAY, WON_A, WON_B} state_t;

    localparam logic [WIDTH-1:0] WIN = WIDTH'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] score_a_q, score_a_d;
    logic [WIDTH-1:0] score_b_q, score_b_d;
    logic             modif_a_d, modif_b_d;
    logic             ev_a, ev_b;

    assign ev_a = bus.ModifA & ~modif_a_d;
    assign ev_b = bus.ModifB & ~modif_b_d;

    always_ff @(posedge clock) begin
        // Edge history follows the inputs even in reset so a held request is not replayed.
        modif_a_d <= bus.ModifA;
        modif_b_d <= bus.ModifB;
        if (Reset) begin
            state_q   <= PLAY;
            score_a_q <= '0;
            score_b_q <= '0;
        end else begin
            state_q   <= state_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        if (state_q == PLAY) begin
            if (ev_a) begin
                if (bus.Modo)
                    score_a_d = score_a_q + 1'b1;
                else if (score_a_q != '0)
                    score_a_d = score_a_q - 1'b1;
            end
            if (ev_b) begin
                if (bus.Modo)
                    score_b_d = score_b_q + 1'b1;
                else if (score_b_q != '0)
                    score_b_d = score_b_q - 1'b1;
            end
            if (ev_a && bus.Modo && score_a_d == WIN)
                state_d = WON_A;
            else if (ev_b && bus.Modo && score_b_d == WIN)
                state_d = WON_B;
        end
    end

    assign bus.ScoreA   = score_a_q;
    assign bus.ScoreB   = score_b_q;
    assign bus.GanadorA = (state_q == WON_A);
    assign bus.GanadorB = (state_q == WON_B);

`ifdef ROUND_COUNT_EN
    logic [7:0] rondas_q;
    logic [8:0] rondas_sum;

    assign rondas_sum = {1'b0, rondas_q} + {7'd0, ev_a} + {7'd0, ev_b};

    always_ff @(posedge clock) begin
        if (Reset)
            rondas_q <= '0;
        else if (state_q == PLAY)
            rondas_q <= rondas_sum[8] ? 8'hFF : rondas_sum[7:0];
    end

    assign bus.Rondas = rondas_q;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: per-cycle comparison against a game-rule model
// plus hand-computed literal checkpoints.
module tb_score_keeper;
    localparam int WIDTH = 4;
    localparam int WIN   = 5;

    logic clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    score_keeper_if #(.WIDTH(WIDTH)) bus ();

    score_keeper #(.WIDTH(WIDTH), .WIN_SCORE(WIN)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Game-rule model: integer scores, a winner id, and the previous request levels.
    int  m_a, m_b, m_winner, m_rounds;
    bit  m_prev_a, m_prev_b, m_valid;

    initial begin
        m_a = 0; m_b = 0; m_winner = 0; m_rounds = 0;
        m_prev_a = 0; m_prev_b = 0; m_valid = 0;
    end

    always @(posedge clock) begin
        bit ra, rb;
        ra = bus.ModifA && !m_prev_a;
        rb = bus.ModifB && !m_prev_b;
        m_prev_a = bus.ModifA;
        m_prev_b = bus.ModifB;
        if (Reset) begin
            m_a = 0; m_b = 0; m_winner = 0; m_rounds = 0;
            m_valid = 1;
        end else if (m_winner == 0) begin
            if (ra) m_a = bus.Modo ? m_a + 1 : (m_a > 0 ? m_a - 1 : 0);
            if (rb) m_b = bus.Modo ? m_b + 1 : (m_b > 0 ? m_b - 1 : 0);
            m_rounds = m_rounds + int'(ra) + int'(rb);
            if (m_rounds > 255) m_rounds = 255;
            if (m_a == WIN)      m_winner = 1;
            else if (m_b == WIN) m_winner = 2;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_ScoreA",   int'(bus.ScoreA),   m_a);
            check("model_ScoreB",   int'(bus.ScoreB),   m_b);
            check("model_GanadorA", int'(bus.GanadorA), int'(m_winner == 1));
            check("model_GanadorB", int'(bus.GanadorB), int'(m_winner == 2));
`ifdef ROUND_COUNT_EN
            check("model_Rondas",   int'(bus.Rondas),   m_rounds);
`endif
        end
    end

    task automatic cyc(input logic r, input logic m, input logic a, input logic b);
        Reset      = r;
        bus.Modo   = m;
        bus.ModifA = a;
        bus.ModifB = b;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_a(input logic m);
        cyc(0, m, 1, 0);
        cyc(0, m, 0, 0);
    endtask

    task automatic pulse_b(input logic m);
        cyc(0, m, 0, 1);
        cyc(0, m, 0, 0);
    endtask

    initial begin
        Reset = 1; bus.Modo = 0; bus.ModifA = 0; bus.ModifB = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_ScoreA", int'(bus.ScoreA), 0);
        check("reset_ScoreB", int'(bus.ScoreB), 0);
        check("reset_GanA",   int'(bus.GanadorA), 0);
        check("reset_GanB",   int'(bus.GanadorB), 0);

        // Five single-cycle adds on A; winner flag arrives with the fifth point.
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 1, 0);
            check("a_step", int'(bus.ScoreA), i);
            check("a_step_GanA", int'(bus.GanadorA), (i == 5) ? 1 : 0);
            cyc(0, 1, 0, 0);
        end
        check("a_win_GanB", int'(bus.GanadorB), 0);

        // Subtract at zero saturates; a long held request counts once.
        cyc(1, 0, 0, 0);
        pulse_b(0);
        check("b_sub_zero", int'(bus.ScoreB), 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1);
        check("b_held", int'(bus.ScoreB), 1);
        cyc(0, 1, 0, 0);

        // Decrements on a non-zero score.
        pulse_a(1); pulse_a(1);
        pulse_a(0);
        check("a_dec", int'(bus.ScoreA), 1);
        pulse_a(0); pulse_a(0);
        check("a_dec_sat", int'(bus.ScoreA), 0);

        // Both at 4, then simultaneous winning add: A has priority.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            pulse_a(1);
            pulse_b(1);
        end
        check("pre_tie_A", int'(bus.ScoreA), 4);
        check("pre_tie_B", int'(bus.ScoreB), 4);
        cyc(0, 1, 1, 1);
        check("tie_A", int'(bus.ScoreA), 5);
        check("tie_B", int'(bus.ScoreB), 5);
        check("tie_GanA", int'(bus.GanadorA), 1);
        check("tie_GanB", int'(bus.GanadorB), 0);
        cyc(0, 1, 0, 0);

        // Frozen in WON_A.
        pulse_a(0); pulse_b(0); pulse_a(1); pulse_b(1);
        cyc(0, 0, 1, 1); cyc(0, 0, 0, 0);
        check("frozen_A", int'(bus.ScoreA), 5);
        check("frozen_B", int'(bus.ScoreB), 5);
        check("frozen_GanA", int'(bus.GanadorA), 1);
        cyc(1, 0, 0, 0);
        check("clear_A", int'(bus.ScoreA), 0);
        check("clear_B", int'(bus.ScoreB), 0);
        check("clear_GanA", int'(bus.GanadorA), 0);

        // Request high through reset is not counted afterwards.
        cyc(1, 1, 1, 0);
        cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
        check("held_thru_reset", int'(bus.ScoreA), 0);
        cyc(0, 1, 0, 0);
        pulse_a(1);
        check("pre_reset_rise", int'(bus.ScoreA), 1);
        cyc(1, 1, 1, 0);
        check("reset_with_rise", int'(bus.ScoreA), 0);
        cyc(0, 1, 1, 0);
        check("reset_with_rise_after", int'(bus.ScoreA), 0);
        cyc(0, 1, 0, 0);

        // B wins alone.
        cyc(1, 0, 0, 0);
        pulse_a(1);
        for (int i = 0; i < 5; i++) pulse_b(1);
        check("b_win_B", int'(bus.ScoreB), 5);
        check("b_win_GanB", int'(bus.GanadorB), 1);
        check("b_win_GanA", int'(bus.GanadorA), 0);
        pulse_a(1);
        check("b_win_frozen_A", int'(bus.ScoreA), 1);

        // Round counter: 3 A-adds, 2 B-subtracts, 1 simultaneous pair.
        cyc(1, 0, 0, 0);
        pulse_a(1); pulse_a(1); pulse_a(1);
        pulse_b(0); pulse_b(0);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 0);
        check("rnd_A", int'(bus.ScoreA), 4);
        check("rnd_B", int'(bus.ScoreB), 1);
`ifdef ROUND_COUNT_EN
        check("rnd_count", int'(bus.Rondas), 7);
`endif
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
